mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath that follows the single-cycle SingleCPU. It sequences fetch, decode, execute, memory and writeback over several clocks. It drives all datapath mux selects and enables, plus ALU control, and stalls on a memory ready handshake. It sits beside the datapath, decoding the IR opcode/funct fields and the ALU zero flag.

Parameters:
ALU_CTRL_W, 4, width of alu_ctrl
STATE_W, 4, width of the state debug output

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in BRANCH
mem_ready  input  1  memory completes the access this cycle
pc_en  output  1  PC register load enable
ir_write  output  1  IR load enable
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
iord  output  1  memory address select: 0=PC, 1=ALUOut
reg_write  output  1  register file write enable
reg_dst  output  1  write register select: 0=rt, 1=rd
mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR
alu_src_a  output  1  ALU A select: 0=PC, 1=rs
alu_src_b  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_ctrl  output  ALU_CTRL_W  ALU op: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
pc_src  output  2  next PC select: 00=ALU result, 01=ALUOut, 10=jump target
illegal  output  1  one-cycle pulse on an unsupported opcode or funct
state  output  STATE_W  current state encoding, for debug

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high on rst.
- State register only. Outputs are a combinational decode of state, gated with mem_ready/zero where noted.
- Any output not listed for a state is 0. Default alu_ctrl is 0010.
- State encodings and actions:
  - FETCH=0: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, alu_ctrl=add. ir_write=pc_en=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE=1: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000000 -> RTYPE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDI_EX
    - 000010 (j) -> JUMP
    - anything else -> TRAP
  - MEMADR=2: alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD=3: mem_read=1, iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB=4: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
  - MEMWR=5: mem_write=1, iord=1. Holds until mem_ready, then goes to FETCH.
  - RTYPE=6: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
    - 0x20 -> add, 0x22 -> sub, 0x24 -> and, 0x25 -> or, 0x2A -> slt
    - any other funct -> TRAP next, instead of ALUWB
  - ALUWB=7: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero. Goes to FETCH.
  - ADDI_EX=9: alu_src_a=1, alu_src_b=10, add. Goes to ADDI_WB.
  - ADDI_WB=10: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - JUMP=11: pc_src=10, pc_en=1. Goes to FETCH.
  - TRAP=12: illegal=1 for exactly one cycle, no writes. Goes to FETCH, so the instruction is skipped; PC was already advanced in FETCH.
  - Encodings 13-15 are unused and go to FETCH.
- Latency with mem_ready held at 1, in cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset: rst=1 at a clock edge forces FETCH from any state, including mid-memory access. After reset, all outputs equal the FETCH decode: mem_read=1, alu_src_b=01, pc_en=ir_write=mem_ready, everything else 0.
- Simultaneous rst and mem_ready: rst wins, no state advance, and the bench must not expect IR/PC updates beyond that edge.
- mem_write and reg_write are never asserted in the same cycle.
- mem_read and mem_write are never asserted in the same cycle.

Optional Feature:
MC_PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on every transition into FETCH from a non-FETCH state, TRAP included.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- lw: opcode 100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. Total 5 cycles.
- R-type sub: opcode 0, funct 0x22 -> alu_ctrl=0110 in state 6, reg_dst=1 in state 7. Illegal funct 0x3F -> state 12, illegal pulses once, then back to 0.
- beq: zero=1 -> pc_en=1 and pc_src=01 in state 8. Repeat with zero=0 -> pc_en=0. Both return to FETCH after 3 cycles.
- Wait states: mem_ready=0 for 3 cycles in FETCH -> state stays 0, pc_en=ir_write=0 for those 3 cycles, then one cycle with both =1. The same check applies in MEMWR: mem_write held high for 4 cycles.
- Reset mid-op: assert rst during MEMRD with mem_ready=0 -> next cycle state=0 and mem_read=1, iord=0, reg_write=0.
- MC_PERF_CNT_EN build: run j, addi, an illegal opcode -> instr_cnt=3, cycle_cnt=10.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl #(
    parameter int ALU_CTRL_W = 4,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ir_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  iord,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            pc_src,
    output logic                  illegal,
    output logic [STATE_W-1:0]    state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instr_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPE   = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDI_EX = 4'd9,
        ADDI_WB = 4'd10,
        JUMP    = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);

    state_t state_q, state_n;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_n;
    end

    assign state = STATE_W'(state_q);

    // Outputs depend only on state, with mem_ready/zero gating the PC/IR enables.
    always_comb begin
        state_n    = state_q;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_n = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = RTYPE;
                    OP_BEQ:       state_n = BRANCH;
                    OP_ADDI:      state_n = ADDI_EX;
                    OP_J:         state_n = JUMP;
                    default:      state_n = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_n   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_n = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_n    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_n = FETCH;
            end
            RTYPE: begin
                alu_src_a = 1'b1;
                state_n   = ALUWB;
                case (funct)
                    6'h20:   alu_ctrl = ALU_ADD;
                    6'h22:   alu_ctrl = ALU_SUB;
                    6'h24:   alu_ctrl = ALU_AND;
                    6'h25:   alu_ctrl = ALU_OR;
                    6'h2A:   alu_ctrl = ALU_SLT;
                    default: state_n  = TRAP;
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_n   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
                state_n   = FETCH;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_n   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                state_n   = FETCH;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_n = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
                state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    // An instruction retires whenever the FSM returns to FETCH, traps included.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state_q != FETCH && state_n == FETCH)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; covers the MC_PERF_CNT_EN build when defined.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, ir_write, mem_read, mem_write, iord, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_ctrl;
    logic [3:0] state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl #(.ALU_CTRL_W(4), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .illegal(illegal), .state(state)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        checks++;
        if ({mem_read, alu_src_b, pc_en, ir_write, mem_write, iord, reg_write, reg_dst,
             mem_to_reg, alu_src_a, pc_src, illegal} !== 14'b1_01_00_000_000_00_0) begin
            errors++; $display("[TB] FAIL reset_outputs got %b",
                {mem_read, alu_src_b, pc_en, ir_write, mem_write, iord, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, pc_src, illegal});
        end
        checks++;
        if (alu_ctrl !== 4'b0010) begin errors++; $display("[TB] FAIL reset_alu_ctrl got %b want 0010", alu_ctrl); end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({pc_en, ir_write} !== 2'b11) begin errors++; $display("[TB] FAIL fetch_ready_en got %b want 11", {pc_en, ir_write}); end
        // rst and mem_ready together: reset wins, no advance
        rst = 1'b1;
        opcode = 6'b100011;
        tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("[TB] FAIL rst_vs_ready got %0d want 0", state); end
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_lw();
        int exp_s[6] = '{0, 1, 2, 3, 4, 0};
        opcode = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state !== exp_s[i][3:0]) begin errors++; $display("[TB] FAIL lw_state[%0d] got %0d want %0d", i, state, exp_s[i]); end
            checks++;
            if ({reg_write, mem_to_reg} !== ((exp_s[i] == 4) ? 2'b11 : 2'b00)) begin
                errors++; $display("[TB] FAIL lw_wb[%0d] got %b", i, {reg_write, mem_to_reg});
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_rtype();
        int exp_a[5] = '{0, 1, 6, 7, 0};
        int exp_b[5] = '{0, 1, 6, 12, 0};
        int ill_cnt = 0;
        opcode = 6'b000000;
        funct = 6'h22;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_a[i][3:0]) begin errors++; $display("[TB] FAIL sub_state[%0d] got %0d want %0d", i, state, exp_a[i]); end
            if (exp_a[i] == 6) begin
                checks++;
                if (alu_ctrl !== 4'b0110) begin errors++; $display("[TB] FAIL sub_alu_ctrl got %b want 0110", alu_ctrl); end
            end
            if (exp_a[i] == 7) begin
                checks++;
                if ({reg_dst, reg_write, mem_to_reg} !== 3'b110) begin errors++; $display("[TB] FAIL sub_wb got %b want 110", {reg_dst, reg_write, mem_to_reg}); end
            end
            if (i < 4) tick();
        end
        funct = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_b[i][3:0]) begin errors++; $display("[TB] FAIL badfunct_state[%0d] got %0d want %0d", i, state, exp_b[i]); end
            if (illegal === 1'b1) ill_cnt++;
            checks++;
            if ({reg_write, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL badfunct_nowrite[%0d] got %b want 00", i, {reg_write, mem_write}); end
            if (i < 4) tick();
        end
        checks++;
        if (ill_cnt != 1) begin errors++; $display("[TB] FAIL illegal_pulses got %0d want 1", ill_cnt); end
        funct = 6'h20;
    endtask

    task automatic test_beq();
        int exp_s[4] = '{0, 1, 8, 0};
        opcode = 6'b000100;
        mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (state !== exp_s[i][3:0]) begin errors++; $display("[TB] FAIL beq%0d_state[%0d] got %0d want %0d", z, i, state, exp_s[i]); end
                if (exp_s[i] == 8) begin
                    checks++;
                    if ({pc_en, pc_src, alu_ctrl} !== {z[0], 2'b01, 4'b0110}) begin
                        errors++; $display("[TB] FAIL beq%0d_ctrl got %b want %b", z, {pc_en, pc_src, alu_ctrl}, {z[0], 2'b01, 4'b0110});
                    end
                end
                if (i < 3) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_addi_jump();
        int exp_a[5] = '{0, 1, 9, 10, 0};
        int exp_j[4] = '{0, 1, 11, 0};
        opcode = 6'b001000;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_a[i][3:0]) begin errors++; $display("[TB] FAIL addi_state[%0d] got %0d want %0d", i, state, exp_a[i]); end
            if (exp_a[i] == 9) begin
                checks++;
                if ({alu_src_a, alu_src_b} !== 3'b110) begin errors++; $display("[TB] FAIL addi_ex got %b want 110", {alu_src_a, alu_src_b}); end
            end
            if (exp_a[i] == 10) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin errors++; $display("[TB] FAIL addi_wb got %b want 100", {reg_write, reg_dst, mem_to_reg}); end
            end
            if (i < 4) tick();
        end
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== exp_j[i][3:0]) begin errors++; $display("[TB] FAIL j_state[%0d] got %0d want %0d", i, state, exp_j[i]); end
            if (exp_j[i] == 11) begin
                checks++;
                if ({pc_en, pc_src} !== 3'b110) begin errors++; $display("[TB] FAIL j_ctrl got %b want 110", {pc_en, pc_src}); end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_wait_states();
        opcode = 6'b101011;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({state, pc_en, ir_write} !== 6'b0000_00) begin errors++; $display("[TB] FAIL fetch_wait[%0d] got %b want 000000", i, {state, pc_en, ir_write}); end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, pc_en, ir_write} !== 6'b0000_11) begin errors++; $display("[TB] FAIL fetch_go got %b want 000011", {state, pc_en, ir_write}); end
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            checks++;
            if ({state, mem_write, iord, reg_write, mem_read} !== 8'b0101_1100) begin
                errors++; $display("[TB] FAIL memwr_hold[%0d] got %b want 01011100", i, {state, mem_write, iord, reg_write, mem_read});
            end
            tick();
        end
        checks++;
        if (state !== 4'd0) begin errors++; $display("[TB] FAIL sw_done got %0d want 0", state); end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd3) begin errors++; $display("[TB] FAIL memrd_reach got %0d want 3", state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({state, mem_read, iord, reg_write} !== 7'b0000_100) begin
            errors++; $display("[TB] FAIL reset_mid got %b want 0000100", {state, mem_read, iord, reg_write});
        end
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        mem_ready = 1'b1;
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) tick();
        opcode = 6'b001000;
        for (int i = 0; i < 4; i++) tick();
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (instr_cnt !== 32'd3) begin errors++; $display("[TB] FAIL instr_cnt got %0d want 3", instr_cnt); end
        checks++;
        if (cycle_cnt !== 32'd10) begin errors++; $display("[TB] FAIL cycle_cnt got %0d want 10", cycle_cnt); end
        checks++;
        if (state !== 4'd0) begin errors++; $display("[TB] FAIL perf_state got %0d want 0", state); end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_addi_jump();
        test_wait_states();
        test_reset_mid();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Exclusivity of strobes, sampled mid-cycle throughout the run
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((mem_write && reg_write) || (mem_read && mem_write)) begin
                errors++; $display("[TB] FAIL strobe_exclusive state %0d mr %b mw %b rw %b", state, mem_read, mem_write, reg_write);
            end
        end
    end

endmodule
